// File: rtl/mii_rx_frame_gen_pkg.sv
// Shared constants and types for the MII receive-side frame generator.
//   - preamble / SFD nibble values
//   - reflected CRC-32 polynomial, init value and good-frame residue
//   - FSM state encoding (also exported on the debug port)
package mii_rx_frame_gen_pkg;

  localparam logic [3:0]  PREAMBLE_NIBBLE = 4'h5;
  localparam logic [7:0]  SFD_BYTE        = 8'hD5;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  // Remainder left in the register after running a frame plus its own FCS
  // through the update; a receive-side checker compares against this.
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_DATA     = 3'd2,
    ST_FCS      = 3'd3,
    ST_DROP     = 3'd4,
    ST_IFG      = 3'd5
  } state_t;

endpackage

// File: rtl/mii_rx_frame_gen_if.sv
// Byte-wide AXI stream carrying whole Ethernet frames (DA through payload).
//   tdata  : frame byte
//   tvalid : byte valid
//   tready : byte accepted on a rising clk edge where tvalid && tready
//   tlast  : last byte of the frame
//   tuser  : frame-error flag, only meaningful on the tlast beat
// Handshake: a beat transfers on every rising edge where tvalid and tready
// are both high. The source holds tdata/tlast/tuser stable while tvalid is
// high and tready is low. tready never depends on tvalid.
interface mii_rx_frame_gen_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser,
                  input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser,
                  output tready);
endinterface

// File: rtl/mii_rx_frame_gen_crc32_byte.sv
// Combinational CRC-32 (reflected, poly 0xEDB88320) update by one byte.
//   crc_in  : running CRC register value
//   data    : byte to fold in, bit 0 first
//   crc_out : updated CRC register value (not inverted)
module crc32_byte
  import mii_rx_frame_gen_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    logic [31:0] c;
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/mii_rx_frame_gen.sv
// PHY-side MII frame generator. Turns byte frames from an AXI stream into
// MII receive signals: preamble + SFD, data nibbles (low first), optional
// CRC-32 FCS, then an inter-frame gap.
//   clk, rst        : MII clock, asynchronous active-high reset
//   s_axis          : frame byte stream (slave side)
//   mii_rxd         : nibble, low nibble of each byte first
//   mii_rx_dv       : data valid
//   mii_rx_er       : receive error
//   start_packet    : one-cycle pulse on the first preamble nibble
//   error_underflow : one-cycle pulse when a frame is aborted
//   busy            : high in every state except IDLE
//   state_dbg       : current FSM state
module mii_rx_frame_gen
  import mii_rx_frame_gen_pkg::*;
#(
  parameter bit          ENABLE_FCS = 1'b1,
  parameter int unsigned IFG_CYCLES = 24
) (
  input  logic              clk,
  input  logic              rst,
  mii_rx_frame_gen_if.slave s_axis,
  output logic [3:0]        mii_rxd,
  output logic              mii_rx_dv,
  output logic              mii_rx_er,
  output logic              start_packet,
  output logic              error_underflow,
  output logic              busy,
  output state_t            state_dbg
);

  // The IDLE cycle that accepts the next byte is the last cycle of the gap,
  // so IFG itself lasts IFG_CYCLES-1 cycles; with a 1-cycle gap the IFG
  // state is skipped entirely.
  localparam state_t     GAP_STATE = (IFG_CYCLES > 1) ? ST_IFG : ST_IDLE;
  localparam logic [7:0] IFG_LAST  = (IFG_CYCLES > 1) ? 8'(IFG_CYCLES - 2) : 8'd0;

  state_t      state;
  logic        phase;         // 0: low nibble on the wire, 1: high nibble
  logic        abort_q;       // error nibble of an underflow is on the wire
  logic        out_of_reset;  // keeps tready low until the first edge after reset
  logic [7:0]  hold_data;
  logic        hold_last;
  logic        hold_err;
  logic [31:0] crc;
  logic [31:0] crc_next;
  logic [3:0]  pre_cnt;
  logic [2:0]  fcs_cnt;
  logic [2:0]  fcs_idx_next;
  logic [7:0]  ifg_cnt;
  logic [31:0] fcs_cur;
  logic [31:0] fcs_next;
  logic        tready;
  logic        accept;

  crc32_byte u_crc (
    .crc_in  (crc),
    .data    (hold_data),
    .crc_out (crc_next)
  );

  // crc already includes the last byte once FCS is entered; fcs_next is the
  // value during the phase-1 cycle of the last byte (first FCS nibble).
  assign fcs_cur      = ~crc;
  assign fcs_next     = ~crc_next;
  assign fcs_idx_next = fcs_cnt + 3'd1;

  always_comb begin
    tready = 1'b0;
    case (state)
      ST_IDLE: tready = out_of_reset;
      ST_DATA: tready = phase & ~hold_last & ~abort_q;
      ST_DROP: tready = 1'b1;
      default: tready = 1'b0;
    endcase
  end

  assign s_axis.tready = tready;
  assign accept        = s_axis.tvalid & tready;
  assign busy          = (state != ST_IDLE);
  assign state_dbg     = state;

  // Registered outputs hold what is on the wire in the current cycle; each
  // branch loads the nibble for the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      phase           <= 1'b0;
      abort_q         <= 1'b0;
      out_of_reset    <= 1'b0;
      hold_data       <= 8'h00;
      hold_last       <= 1'b0;
      hold_err        <= 1'b0;
      crc             <= CRC_INIT;
      pre_cnt         <= 4'd0;
      fcs_cnt         <= 3'd0;
      ifg_cnt         <= 8'd0;
      mii_rxd         <= 4'h0;
      mii_rx_dv       <= 1'b0;
      mii_rx_er       <= 1'b0;
      start_packet    <= 1'b0;
      error_underflow <= 1'b0;
    end else begin
      out_of_reset    <= 1'b1;
      start_packet    <= 1'b0;
      error_underflow <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            hold_data    <= s_axis.tdata;
            hold_last    <= s_axis.tlast;
            hold_err     <= s_axis.tlast & s_axis.tuser;
            crc          <= CRC_INIT;
            pre_cnt      <= 4'd0;
            phase        <= 1'b0;
            state        <= ST_PREAMBLE;
            mii_rxd      <= PREAMBLE_NIBBLE;
            mii_rx_dv    <= 1'b1;
            mii_rx_er    <= 1'b0;
            start_packet <= 1'b1;
          end
        end

        ST_PREAMBLE: begin
          if (pre_cnt == 4'd15) begin
            state     <= ST_DATA;
            phase     <= 1'b0;
            mii_rxd   <= hold_data[3:0];
            mii_rx_er <= hold_err;
          end else begin
            pre_cnt <= pre_cnt + 4'd1;
            // Nibble 15 of the preamble is the upper nibble of the SFD.
            mii_rxd <= (pre_cnt == 4'd14) ? SFD_BYTE[7:4] : PREAMBLE_NIBBLE;
          end
        end

        ST_DATA: begin
          if (abort_q) begin
            abort_q   <= 1'b0;
            state     <= ST_DROP;
            mii_rxd   <= 4'h0;
            mii_rx_dv <= 1'b0;
            mii_rx_er <= 1'b0;
          end else if (!phase) begin
            phase   <= 1'b1;
            mii_rxd <= hold_data[7:4];
          end else begin
            crc   <= crc_next;
            phase <= 1'b0;
            if (hold_last) begin
              if (ENABLE_FCS) begin
                state     <= ST_FCS;
                fcs_cnt   <= 3'd0;
                mii_rxd   <= fcs_next[3:0];
                mii_rx_er <= 1'b0;
              end else begin
                state     <= GAP_STATE;
                ifg_cnt   <= 8'd0;
                mii_rxd   <= 4'h0;
                mii_rx_dv <= 1'b0;
                mii_rx_er <= 1'b0;
              end
            end else if (accept) begin
              hold_data <= s_axis.tdata;
              hold_last <= s_axis.tlast;
              hold_err  <= s_axis.tlast & s_axis.tuser;
              mii_rxd   <= s_axis.tdata[3:0];
              mii_rx_er <= s_axis.tlast & s_axis.tuser;
            end else begin
              // Source ran dry mid-frame: mark the frame bad on the wire
              // for one nibble, then flush the rest of it.
              abort_q         <= 1'b1;
              error_underflow <= 1'b1;
              mii_rxd         <= 4'h0;
              mii_rx_er       <= 1'b1;
            end
          end
        end

        ST_FCS: begin
          if (fcs_cnt == 3'd7) begin
            state     <= GAP_STATE;
            ifg_cnt   <= 8'd0;
            mii_rxd   <= 4'h0;
            mii_rx_dv <= 1'b0;
          end else begin
            fcs_cnt <= fcs_idx_next;
            mii_rxd <= fcs_cur[{fcs_idx_next, 2'b00} +: 4];
          end
        end

        ST_DROP: begin
          if (accept && s_axis.tlast) begin
            state   <= GAP_STATE;
            ifg_cnt <= 8'd0;
          end
        end

        ST_IFG: begin
          if (ifg_cnt == IFG_LAST) begin
            state <= ST_IDLE;
          end else begin
            ifg_cnt <= ifg_cnt + 8'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mii_rx_frame_gen.sv
module tb_mii_rx_frame_gen;
  import mii_rx_frame_gen_pkg::*;

  localparam int A_IFG   = 24;
  localparam int TIMEOUT = 400;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT a: FCS on, 24-cycle gap. DUT b: FCS off, 1-cycle gap.
  mii_rx_frame_gen_if ax ();
  mii_rx_frame_gen_if bx ();

  logic [3:0] a_rxd, b_rxd;
  logic       a_dv, a_er, a_sp, a_uf, a_busy;
  logic       b_dv, b_er, b_sp, b_uf, b_busy;
  state_t     a_st, b_st;

  mii_rx_frame_gen #(.ENABLE_FCS(1'b1), .IFG_CYCLES(A_IFG)) dut_a (
    .clk(clk), .rst(rst), .s_axis(ax),
    .mii_rxd(a_rxd), .mii_rx_dv(a_dv), .mii_rx_er(a_er),
    .start_packet(a_sp), .error_underflow(a_uf), .busy(a_busy),
    .state_dbg(a_st)
  );

  mii_rx_frame_gen #(.ENABLE_FCS(1'b0), .IFG_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .s_axis(bx),
    .mii_rxd(b_rxd), .mii_rx_dv(b_dv), .mii_rx_er(b_er),
    .start_packet(b_sp), .error_underflow(b_uf), .busy(b_busy),
    .state_dbg(b_st)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- scoreboard: {er, rxd} per dv cycle ----------------
  logic [4:0] exp_q[$];
  logic [4:0] expb_q[$];

  task automatic push(input bit sel, input logic [4:0] v);
    if (sel) expb_q.push_back(v);
    else     exp_q.push_back(v);
  endtask

  function automatic logic [31:0] fcs_of(input logic [7:0] d[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (d[i]) begin
      c = c ^ {24'h0, d[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic push_preamble(input bit sel);
    for (int i = 0; i < 15; i++) push(sel, 5'h05);
    push(sel, 5'h0D);
  endtask

  task automatic push_byte(input bit sel, input logic [7:0] b, input bit er);
    push(sel, {er, b[3:0]});
    push(sel, {er, b[7:4]});
  endtask

  task automatic push_fcs(input logic [31:0] fcs);
    logic [31:0] t;
    for (int i = 0; i < 8; i++) begin
      t = fcs >> (4 * i);
      exp_q.push_back({1'b0, t[3:0]});
    end
  endtask

  // Whole frame; FCS only for DUT a.
  task automatic push_frame(input bit sel, input logic [7:0] frm[$], input bit user_last);
    push_preamble(sel);
    for (int i = 0; i < frm.size(); i++)
      push_byte(sel, frm[i], user_last && (i == frm.size() - 1));
    if (!sel) push_fcs(fcs_of(frm));
  endtask

  // ---------------- monitors ----------------
  int a_run, a_gap, a_last_run, a_last_gap, a_sp_cnt, a_uf_cnt;
  int b_run, b_gap, b_last_run, b_last_gap, b_sp_cnt, b_uf_cnt;
  bit a_seen, b_seen;

  always @(negedge clk) begin
    if (rst) begin
      a_run = 0; a_gap = 0; a_seen = 0;
    end else begin
      if (a_dv) begin
        if (a_run == 0) begin
          check("a_start_pulse", a_sp, 1'b1);
          if (a_seen) a_last_gap = a_gap;
        end
        a_run++;
        check("a_sb_nonempty", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) check("a_nibble", {a_er, a_rxd}, exp_q.pop_front());
      end else begin
        if (a_run != 0) begin a_last_run = a_run; a_seen = 1; a_gap = 0; end
        a_run = 0;
        a_gap++;
        if (!a_er) check("a_idle_rxd", a_rxd, 4'h0);
      end
      if (a_sp) a_sp_cnt++;
      if (a_uf) a_uf_cnt++;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      b_run = 0; b_gap = 0; b_seen = 0;
    end else begin
      if (b_dv) begin
        if (b_run == 0) begin
          check("b_start_pulse", b_sp, 1'b1);
          if (b_seen) b_last_gap = b_gap;
        end
        b_run++;
        check("b_sb_nonempty", (expb_q.size() != 0), 1'b1);
        if (expb_q.size() != 0) check("b_nibble", {b_er, b_rxd}, expb_q.pop_front());
      end else begin
        if (b_run != 0) begin b_last_run = b_run; b_seen = 1; b_gap = 0; end
        b_run = 0;
        b_gap++;
        if (!b_er) check("b_idle_rxd", b_rxd, 4'h0);
      end
      if (b_sp) b_sp_cnt++;
      if (b_uf) b_uf_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  // Presents a beat after a falling edge; returns on the rising edge that
  // transfers it (tready depends only on DUT registers).
  task automatic drive_beat(input bit sel, input logic [7:0] d, input bit last, input bit user);
    int n;
    @(negedge clk);
    if (sel) begin bx.tdata = d; bx.tvalid = 1'b1; bx.tlast = last; bx.tuser = user; end
    else     begin ax.tdata = d; ax.tvalid = 1'b1; ax.tlast = last; ax.tuser = user; end
    n = 0;
    while (!(sel ? bx.tready : ax.tready) && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check(sel ? "b_accept_wait" : "a_accept_wait", (n < TIMEOUT), 1'b1);
    @(posedge clk);
  endtask

  task automatic bus_idle(input bit sel);
    @(negedge clk);
    if (sel) bx.tvalid = 1'b0;
    else     ax.tvalid = 1'b0;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] frm[$], input bit user_last);
    for (int i = 0; i < frm.size(); i++)
      drive_beat(sel, frm[i], (i == frm.size() - 1), user_last);
  endtask

  task automatic wait_idle(input bit sel);
    int n;
    n = 0;
    @(negedge clk);
    while ((sel ? b_busy : a_busy) && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check(sel ? "b_idle_timeout" : "a_idle_timeout", (sel ? b_busy : a_busy), 1'b0);
    #1;
  endtask

  function automatic void rand_frame(output logic [7:0] frm[$], input int len);
    frm.delete();
    for (int i = 0; i < len; i++) frm.push_back(8'($urandom_range(0, 255)));
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] frm[$];
    logic [7:0] frm2[$];
    int sp0, uf0;

    rst = 1'b1;
    ax.tvalid = 1'b0; ax.tdata = 8'h00; ax.tlast = 1'b0; ax.tuser = 1'b0;
    bx.tvalid = 1'b0; bx.tdata = 8'h00; bx.tlast = 1'b0; bx.tuser = 1'b0;
    a_sp_cnt = 0; a_uf_cnt = 0; a_last_run = 0; a_last_gap = 0;
    b_sp_cnt = 0; b_uf_cnt = 0; b_last_run = 0; b_last_gap = 0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_a_rxd", a_rxd, 4'h0);
    check("rst_a_dv", a_dv, 1'b0);
    check("rst_a_er", a_er, 1'b0);
    check("rst_a_sp", a_sp, 1'b0);
    check("rst_a_uf", a_uf, 1'b0);
    check("rst_a_busy", a_busy, 1'b0);
    check("rst_a_tready", ax.tready, 1'b0);
    check("rst_b_tready", bx.tready, 1'b0);
    check("rst_a_state", 32'(a_st), 32'(ST_IDLE));
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_a_tready", ax.tready, 1'b1);
    check("post_rst_b_tready", bx.tready, 1'b1);

    // Single byte, no FCS, then a second one back to back (1-cycle gap)
    frm = '{8'hA5};
    frm2 = '{8'h3C};
    push_frame(1, frm, 0);
    push_frame(1, frm2, 0);
    send_frame(1, frm, 0);
    check("b_first_run", 32'(b_last_run), 32'd0);
    send_frame(1, frm2, 0);
    bus_idle(1);
    wait_idle(1);
    check("b_run_len", 32'(b_last_run), 32'd18);
    check("b_gap_len", 32'(b_last_gap), 32'd1);
    check("b_sp_count", 32'(b_sp_cnt), 32'd2);
    check("b_sb_drained", 32'(expb_q.size()), 32'd0);

    // FCS check value over "123456789"
    frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    push_preamble(0);
    foreach (frm[i]) push_byte(0, frm[i], 1'b0);
    push_fcs(32'hCBF43926);
    send_frame(0, frm, 0);
    bus_idle(0);
    wait_idle(0);
    check("a_crc_run_len", 32'(a_last_run), 32'd42);
    check("a_crc_sb_drained", 32'(exp_q.size()), 32'd0);

    // Two back-to-back 64-byte frames
    sp0 = a_sp_cnt;
    rand_frame(frm, 64);
    rand_frame(frm2, 64);
    push_frame(0, frm, 0);
    push_frame(0, frm2, 0);
    send_frame(0, frm, 0);
    send_frame(0, frm2, 0);
    bus_idle(0);
    wait_idle(0);
    check("a_b2b_gap", 32'(a_last_gap), 32'(A_IFG));
    check("a_b2b_sp", 32'(a_sp_cnt - sp0), 32'd2);
    check("a_b2b_run_len", 32'(a_last_run), 32'd152);
    check("a_b2b_sb_drained", 32'(exp_q.size()), 32'd0);

    // Underflow after byte 3 of 10
    uf0 = a_uf_cnt;
    rand_frame(frm, 10);
    push_preamble(0);
    for (int i = 0; i < 3; i++) push_byte(0, frm[i], 1'b0);
    push(0, 5'h10);
    for (int i = 0; i < 3; i++) drive_beat(0, frm[i], 1'b0, 1'b0);
    bus_idle(0);
    repeat (8) @(negedge clk);
    check("a_uf_state_drop", 32'(a_st), 32'(ST_DROP));
    for (int i = 3; i < 10; i++) drive_beat(0, frm[i], (i == 9), 1'b0);
    bus_idle(0);
    check("a_uf_state_ifg", 32'(a_st), 32'(ST_IFG));
    wait_idle(0);
    check("a_uf_pulses", 32'(a_uf_cnt - uf0), 32'd1);
    check("a_uf_run_len", 32'(a_last_run), 32'd23);
    check("a_uf_sb_drained", 32'(exp_q.size()), 32'd0);

    // Frame error flag on the last byte (tuser high on every beat)
    rand_frame(frm, 5);
    push_frame(0, frm, 1);
    send_frame(0, frm, 1);
    bus_idle(0);
    wait_idle(0);
    check("a_ferr_run_len", 32'(a_last_run), 32'd34);
    check("a_ferr_sb_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of DATA
    rand_frame(frm, 8);
    push_frame(0, frm, 0);
    drive_beat(0, frm[0], 1'b0, 1'b0);
    drive_beat(0, frm[1], 1'b0, 1'b0);
    #2;
    check("a_mid_state_data", 32'(a_st), 32'(ST_DATA));
    rst = 1'b1;
    ax.tvalid = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_dv", a_dv, 1'b0);
    check("mid_rst_rxd", a_rxd, 4'h0);
    check("mid_rst_er", a_er, 1'b0);
    check("mid_rst_busy", a_busy, 1'b0);
    check("mid_rst_tready", ax.tready, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_release_tready", ax.tready, 1'b1);
    rand_frame(frm, 3);
    push_frame(0, frm, 0);
    send_frame(0, frm, 0);
    bus_idle(0);
    wait_idle(0);
    check("a_after_rst_run_len", 32'(a_last_run), 32'd30);
    check("a_after_rst_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
